axis_tlast_gen: RTL

AXIS_TLAST_GEN -- requirements
Module: axis_tlast_gen

---
 rtl/axis_tlast_gen_if.sv | 25 ++
 rtl/axis_tlast_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/axis_tlast_gen_if.sv
// AXI4-Stream beat bundle used on both sides of axis_tlast_gen.
// master drives the beat fields, slave drives tready.
interface axis_tlast_gen_if #(
    parameter int BUS_WIDTH  = 1,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1
) ();
    logic                    tvalid;
    logic                    tready;
    logic [BUS_WIDTH*8-1:0]  tdata;
    logic [BUS_WIDTH-1:0]    tkeep;
    logic                    tlast;
    logic [USER_WIDTH-1:0]   tuser;
    logic [DEST_WIDTH-1:0]   tdest;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser, tdest,
        output tready
    );
endinterface

// File: rtl/axis_tlast_gen.sv
// One-beat holding stage that frames an AXI4-Stream by beat count or idle timeout.
// Define AXIS_TLAST_GEN_TIMEOUT_EN to build the idle timer; otherwise timeout_cycles is ignored.
module axis_tlast_gen #(
    parameter int BUS_WIDTH  = 1,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  arst,
    axis_tlast_gen_if.slave       s_axis,
    axis_tlast_gen_if.master      m_axis,
    input  logic [CNT_WIDTH-1:0]  pkt_beats,
    input  logic [CNT_WIDTH-1:0]  timeout_cycles
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        SEND  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [BUS_WIDTH*8-1:0]  data_q, data_d;
    logic [BUS_WIDTH-1:0]    keep_q, keep_d;
    logic [USER_WIDTH-1:0]   user_q, user_d;
    logic [DEST_WIDTH-1:0]   dest_q, dest_d;
    logic                    last_q, last_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]    limit_q, limit_d;

    logic                    s_rdy;
    logic                    accept;
    logic                    close;
    logic [CNT_WIDTH-1:0]    lim;
    logic                    expire;

`ifdef AXIS_TLAST_GEN_TIMEOUT_EN
    logic [CNT_WIDTH-1:0]    timer_q, timer_d;

    always_comb begin
        expire = (timeout_cycles != '0) &&
                 (timer_q == CNT_WIDTH'(timeout_cycles - 1'b1));
    end
`else
    logic                    unused_timeout;

    assign expire         = 1'b0;
    assign unused_timeout = ^timeout_cycles;
`endif

    // Ready only while empty or while the held beat drains this cycle.
    always_comb begin
        s_rdy  = !arst &&
                 ((state_q == EMPTY) ||
                  ((state_q == SEND) && m_axis.tready));
        accept = s_axis.tvalid && s_rdy;
        // The first beat of a packet uses the live limit; later beats the latched one.
        lim    = (cnt_q == '0) ? pkt_beats : limit_q;
        close  = s_axis.tlast ||
                 ((lim != '0) && (CNT_WIDTH'(cnt_q + 1'b1) == lim));
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        keep_d  = keep_q;
        user_d  = user_q;
        dest_d  = dest_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
`ifdef AXIS_TLAST_GEN_TIMEOUT_EN
        timer_d = timer_q;
        if ((state_q == HOLD) && (timer_q != '1)) begin
            timer_d = timer_q + 1'b1;
        end
`endif

        unique case (state_q)
            EMPTY: begin
                state_d = EMPTY;
            end
            HOLD: begin
                // A waiting successor beats a coincident timeout.
                if (s_axis.tvalid) begin
                    state_d = SEND;
                    last_d  = 1'b0;
                end else if (expire) begin
                    state_d = SEND;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            SEND: begin
                if (m_axis.tready) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (accept) begin
            data_d = s_axis.tdata;
            keep_d = s_axis.tkeep;
            user_d = s_axis.tuser;
            dest_d = s_axis.tdest;
            if (cnt_q == '0) begin
                limit_d = pkt_beats;
            end
            if (close) begin
                state_d = SEND;
                last_d  = 1'b1;
                cnt_d   = '0;
            end else begin
                state_d = HOLD;
                last_d  = 1'b0;
                cnt_d   = cnt_q + 1'b1;
`ifdef AXIS_TLAST_GEN_TIMEOUT_EN
                timer_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            keep_q  <= '0;
            user_q  <= '0;
            dest_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            limit_q <= '0;
`ifdef AXIS_TLAST_GEN_TIMEOUT_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            user_q  <= user_d;
            dest_q  <= dest_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
`ifdef AXIS_TLAST_GEN_TIMEOUT_EN
            timer_q <= timer_d;
`endif
        end
    end

    assign s_axis.tready = s_rdy;
    assign m_axis.tvalid = !arst && (state_q == SEND);
    assign m_axis.tdata  = data_q;
    assign m_axis.tkeep  = keep_q;
    assign m_axis.tuser  = user_q;
    assign m_axis.tdest  = dest_q;
    assign m_axis.tlast  = last_q;

endmodule
